cla_pipe_adder: RTL and testbench

- Pipelined WIDTH-bit adder that sums partial-product rows downstream of the Vedic multiplier's combinational 4-bit carry-lookahead slices.
- Splits the add into STAGES register-separated carry-lookahead slices. A slice's carry-out is registered into the next stage.
- Carries a valid/ready handshake with full backpressure, so it can sit between the partial-product generator and the final signed-product register.

---
 rtl/cla_pipe_adder_pkg.sv | 32 +++
 rtl/cla_pipe_adder_slice.sv | 29 ++
 rtl/cla_pipe_adder.sv | 101 ++++++++++
 tb/tb_cla_pipe_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared adder definitions: default geometry, the result record used by the
// signed-product stage, and the 4-bit carry-lookahead cell.
package cla_pipe_adder_pkg;

    localparam int ADD_WIDTH  = 32;
    localparam int ADD_STAGES = 4;
    localparam int ADD_SLICE  = ADD_WIDTH / ADD_STAGES;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] sum;
        logic                 cout;
        logic                 ovf;
    } add_result_t;

    // Returns {carry_out, sum[3:0]}; every carry is a flat generate/propagate term.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

// File: rtl/cla_pipe_adder_slice.sv
// Combinational SLICE-bit adder: a chain of 4-bit carry-lookahead cells.
module cla_slice
    import cla_pipe_adder_pkg::*;
#(
    parameter int SLICE = ADD_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    localparam int CELLS = SLICE / 4;

    logic [CELLS:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        logic [4:0] r;
        assign r            = cla4(a[4*i +: 4], b[4*i +: 4], c[i]);
        assign sum[4*i +: 4] = r[3:0];
        assign c[i+1]       = r[4];
    end

    assign cout = c[CELLS];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder with valid/ready backpressure. Rank 0
// registers the operands; rank k+1 holds the result of slice k.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH  = ADD_WIDTH,
    parameter int STAGES = ADD_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;

    function automatic logic ovf_of(input logic a_msb, input logic b_msb,
                                    input logic s_msb, input logic c_out);
        // a^b^s at the MSB recovers the carry into the MSB.
        return a_msb ^ b_msb ^ s_msb ^ c_out;
    endfunction

    logic             vld_p [0:STAGES];
    logic             cry_p [0:STAGES];
    logic [WIDTH-1:0] opa_p [0:STAGES-1];
    logic [WIDTH-1:0] opb_p [0:STAGES-1];
    logic [WIDTH-1:0] sum_p [1:STAGES];
    logic             ovf_p;

    logic [SLICE-1:0] st_sum  [0:STAGES-1];
    logic             st_cout [0:STAGES-1];
    logic [WIDTH-1:0] st_acc  [0:STAGES-1];

    logic stall;

    assign stall    = vld_p[STAGES] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(.SLICE(SLICE)) u_slice (
            .a    (opa_p[k][k*SLICE +: SLICE]),
            .b    (opb_p[k][k*SLICE +: SLICE]),
            .cin  (cry_p[k]),
            .sum  (st_sum[k]),
            .cout (st_cout[k])
        );
        // Bits above the finished slices are always zero, so OR merges the new slice in.
        if (k == 0) begin : g_first
            assign st_acc[k] = WIDTH'(st_sum[k]);
        end else begin : g_next
            assign st_acc[k] = sum_p[k] | (WIDTH'(st_sum[k]) << (k*SLICE));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= STAGES; k++) begin
                vld_p[k] <= 1'b0;
                cry_p[k] <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                opa_p[k]   <= '0;
                opb_p[k]   <= '0;
                sum_p[k+1] <= '0;
            end
            ovf_p <= 1'b0;
        end else if (!stall) begin
            // rank 0: operand capture
            vld_p[0] <= in_valid;
            cry_p[0] <= cin;
            opa_p[0] <= a;
            opb_p[0] <= b;
            // ranks 1..STAGES: slice results plus de-skewed lower sum bits
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k+1] <= vld_p[k];
                cry_p[k+1] <= st_cout[k];
                sum_p[k+1] <= st_acc[k];
            end
            for (int k = 0; k < STAGES-1; k++) begin
                opa_p[k+1] <= opa_p[k];
                opb_p[k+1] <= opb_p[k];
            end
            ovf_p <= ovf_of(opa_p[STAGES-1][WIDTH-1], opb_p[STAGES-1][WIDTH-1],
                            st_acc[STAGES-1][WIDTH-1], st_cout[STAGES-1]);
        end
    end

    assign out_valid = vld_p[STAGES];
    assign sum       = sum_p[STAGES];
    assign cout      = cry_p[STAGES];
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vector table, streaming,
// stall, random handshake and mid-flight reset, all against an arithmetic model.
module tb_cla_pipe_adder;

    localparam int W   = 32;
    localparam int LAT = 4;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    cla_pipe_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_edge;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t q[$];
    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b0;
    bit   last_in_fire = 1'b0;

    function automatic exp_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        exp_t         r;
        logic [63:0]  u;
        longint       s;
        u = {32'b0, x} + {32'b0, y} + {63'b0, c};
        s = longint'($signed(x)) + longint'($signed(y)) + (c ? 64'sd1 : 64'sd0);
        r.sum      = u[W-1:0];
        r.cout     = u[W];
        r.ovf      = (s > SMAX) || (s < SMIN);
        r.acc_edge = 0;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Called at edge+1: observe handshakes, update the scoreboard, advance one clock.
    task automatic cycle();
        exp_t e;
        bit   inf;
        bit   outf;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        if (outf) begin
            n_out++;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got output %0h with nothing outstanding", sum);
            end else begin
                e = q.pop_front();
                check("sb_sum", 64'(sum), 64'(e.sum));
                check("sb_cout", 64'(cout), 64'(e.cout));
                check("sb_ovf", 64'(ovf), 64'(e.ovf));
                if (chk_lat) check("sb_latency", 64'(cyc - e.acc_edge), 64'(LAT));
            end
        end
        if (inf) begin
            e = ref_add(a, b, cin);
            e.acc_edge = cyc + 1;
            q.push_back(e);
        end
        last_in_fire = inf;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (q.size() != 0 || out_valid); i++) cycle();
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic rand_op();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        logic [W-1:0] held_sum;
        logic held_cout;
        logic held_ovf;

        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{32'h0000_000F, 32'h0000_00F0, 1'b1, 32'h0000_0100, 1'b0, 1'b0});
        vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        cycle();

        // Directed vectors, one at a time, with exact timing.
        chk_lat = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            a        = vecs[i].a;
            b        = vecs[i].b;
            cin      = vecs[i].cin;
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            repeat (LAT - 1) cycle();
            check("vec_early_valid", 64'(out_valid), 64'd0);
            cycle();
            check("vec_valid", 64'(out_valid), 64'd1);
            check("vec_sum", 64'(sum), 64'(vecs[i].sum));
            check("vec_cout", 64'(cout), 64'(vecs[i].cout));
            check("vec_ovf", 64'(ovf), 64'(vecs[i].ovf));
            cycle();
            check("vec_valid_one_cycle", 64'(out_valid), 64'd0);
        end

        // Eight back-to-back random operations.
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
        end
        drain();
        check("stream_count", 64'(n_out - base), 64'd8);

        // Five-cycle stall mid-stream with in_valid held high.
        chk_lat  = 1'b0;
        base     = n_out;
        rand_op();
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            out_ready = !(t >= 8 && t < 13);
            #1;
            if (t == 8) begin
                held_sum  = sum;
                held_cout = cout;
                held_ovf  = ovf;
            end
            if (!out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_sum_hold", 64'(sum), 64'(held_sum));
                check("stall_cout_hold", 64'(cout), 64'(held_cout));
                check("stall_ovf_hold", 64'(ovf), 64'(held_ovf));
            end
            cycle();
            if (last_in_fire) rand_op();
        end
        drain();

        // Random valid/ready traffic.
        rand_op();
        for (int t = 0; t < 300; t++) begin
            if (!in_valid || last_in_fire) rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            cycle();
        end
        drain();

        // Reset while three operations are in flight.
        for (int i = 0; i < 3; i++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("postrst_no_output", 64'(out_valid), 64'd0);
            cycle();
        end
        chk_lat  = 1'b1;
        a        = 32'h00FF_00FF;
        b        = 32'h0001_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (LAT) cycle();
        check("postrst_valid", 64'(out_valid), 64'd1);
        check("postrst_sum", 64'(sum), 64'h0100_0100);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
